// File: rtl/ifmap_stream_framer_pkg.sv
// Shared definitions for the tagged ifmap stream: word layout and framer states.
// The consumer-side unpack uses the same START_BIT/END_BIT indices.
package ifmap_stream_framer_pkg;

    localparam int IFMAP_DATA_WIDTH = 16;
    localparam int FRAME_W          = IFMAP_DATA_WIDTH + 2;
    localparam int START_BIT        = IFMAP_DATA_WIDTH + 1;
    localparam int END_BIT          = IFMAP_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } frame_state_t;

endpackage

// File: rtl/framer_skid_fifo.sv
// Two-entry holding FIFO with an empty-bypass path, so a word landing while
// the FIFO is empty and the consumer is ready leaves in the same cycle.
module framer_skid_fifo #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count_q;
    logic             pop;
    logic             bypass;
    logic             store;
    logic             retire;

    assign out_valid = (count_q != 2'd0) || push;
    assign out_data  = (count_q != 2'd0) ? mem[rd_ptr] : (push ? push_data : '0);
    assign pop       = out_valid && out_ready;
    // A bypassed word never touches the storage, so pointers stay put.
    assign bypass    = (count_q == 2'd0) && push && pop;
    assign store     = push && !bypass;
    assign retire    = pop && !bypass;
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (retire) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + {1'b0, store} - {1'b0, retire};
        end
    end

endmodule

// File: rtl/ifmap_stream_framer.sv
// Reads an ifmap frame row by row from a synchronous SRAM, tags each element
// with start/end-of-row bits and streams the words into the ifmap circular_buffer.
module ifmap_stream_framer
    import ifmap_stream_framer_pkg::*;
#(
    parameter int DATA_WIDTH = IFMAP_DATA_WIDTH,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] row_stride,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [LEN_WIDTH-1:0]  num_rows,
    output logic                  src_rd_en,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  buf_full,
    output logic                  buf_write_en,
    output logic [DATA_WIDTH+1:0] buf_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    frame_state_t          state_q;
    frame_state_t          state_d;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [LEN_WIDTH-1:0]  row_len_q;
    logic [LEN_WIDTH-1:0]  num_rows_q;
    logic [LEN_WIDTH-1:0]  col_q;
    logic [LEN_WIDTH-1:0]  row_q;
    logic [ADDR_WIDTH-1:0] row_base_q;
    logic                  in_flight_q;
    logic [1:0]            tag_q;
    logic [1:0]            fifo_count;
    logic                  fifo_valid;
    logic                  rd_issue;
    logic                  last_col;
    logic                  last_row;
    logic                  accept;
    logic                  drained;

    assign accept   = (state_q == ST_IDLE) && start;
    assign last_col = (col_q == row_len_q - LEN_ONE);
    assign last_row = (row_q == num_rows_q - LEN_ONE);
    // Counting the in-flight read guarantees its landing slot in the FIFO.
    assign rd_issue = (state_q == ST_RUN) &&
                      (({1'b0, fifo_count} + {2'b00, in_flight_q}) < 3'd2);

    assign src_rd_en    = rd_issue;
    assign src_addr     = rd_issue ? (row_base_q + ADDR_WIDTH'(col_q)) : '0;
    assign buf_write_en = fifo_valid && !buf_full;

    // Look one cycle ahead so done lands right after the final write.
    assign drained = in_flight_q ? ((fifo_count == 2'd0) && buf_write_en)
                                 : ((fifo_count == 2'd0) ||
                                    ((fifo_count == 2'd1) && buf_write_en));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((row_len == '0) || (num_rows == '0)) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (rd_issue && last_col && last_row) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drained) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Row base advances by the stride at each row wrap, avoiding a multiplier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stride_q    <= '0;
            row_len_q   <= '0;
            num_rows_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
            in_flight_q <= 1'b0;
            tag_q       <= 2'b00;
        end else begin
            in_flight_q <= rd_issue;
            if (accept) begin
                stride_q   <= row_stride;
                row_len_q  <= row_len;
                num_rows_q <= num_rows;
                row_base_q <= base_addr;
                col_q      <= '0;
                row_q      <= '0;
            end else if (rd_issue) begin
                tag_q <= {col_q == '0, last_col};
                if (last_col) begin
                    col_q      <= '0;
                    row_q      <= row_q + LEN_ONE;
                    row_base_q <= row_base_q + stride_q;
                end else begin
                    col_q <= col_q + LEN_ONE;
                end
            end
        end
    end

    framer_skid_fifo #(
        .WIDTH(DATA_WIDTH + 2)
    ) u_skid_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight_q),
        .push_data ({tag_q, src_data}),
        .out_ready (!buf_full),
        .out_valid (fifo_valid),
        .out_data  (buf_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ifmap_stream_framer.sv
// Scoreboard bench for ifmap_stream_framer: stimulus pushes expected reads and
// words, a negedge monitor pops and compares them as the DUT presents them.
module tb_ifmap_stream_framer;
    import ifmap_stream_framer_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int LW = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [AW-1:0]      base_addr = '0;
    logic [AW-1:0]      row_stride = '0;
    logic [LW-1:0]      row_len = '0;
    logic [LW-1:0]      num_rows = '0;
    logic               src_rd_en;
    logic [AW-1:0]      src_addr;
    logic [DW-1:0]      src_data = '0;
    logic               buf_full = 1'b0;
    logic               buf_write_en;
    logic [FRAME_W-1:0] buf_data;
    logic               busy;
    logic               done;

    logic [DW-1:0]      sram [256];
    logic [FRAME_W-1:0] exp_words [$];
    logic [AW-1:0]      exp_addrs [$];

    int cyc = 0;
    int checks_total = 0;
    int checks_passed = 0;
    int writes_total = 0;
    int done_total = 0;
    int last_write_cyc = -1;
    int first_write_cyc = -1;
    int stall_reads = 0;
    int stall_writes = 0;

    ifmap_stream_framer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .row_stride  (row_stride),
        .row_len     (row_len),
        .num_rows    (num_rows),
        .src_rd_en   (src_rd_en),
        .src_addr    (src_addr),
        .src_data    (src_data),
        .buf_full    (buf_full),
        .buf_write_en(buf_write_en),
        .buf_data    (buf_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (src_rd_en) src_data <= sram[src_addr];
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Model: element (r,c) at base + r*stride + c, tags from the column index.
    task automatic expect_frame(input int base, input int stride, input int len,
                                input int rows);
        logic [AW-1:0] a;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < len; c++) begin
                a = AW'(base + r * stride + c);
                exp_addrs.push_back(a);
                exp_words.push_back({c == 0, c == len - 1, sram[a]});
            end
        end
    endtask

    initial begin
        logic [FRAME_W-1:0] w;
        logic [AW-1:0]      a;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (buf_write_en) begin
                    if (exp_words.size() == 0) begin
                        checks_total++;
                        $display("[TB] FAIL unexpected_write: got 0x%0h, expected no write", buf_data);
                    end else begin
                        w = exp_words.pop_front();
                        check_output("write_data", 32'(buf_data), 32'(w));
                    end
                    writes_total++;
                    last_write_cyc = cyc;
                    if (first_write_cyc < 0) first_write_cyc = cyc;
                    if (buf_full) stall_writes++;
                end
                if (src_rd_en) begin
                    if (exp_addrs.size() == 0) begin
                        checks_total++;
                        $display("[TB] FAIL unexpected_read: got addr %0d, expected no read", src_addr);
                    end else begin
                        a = exp_addrs.pop_front();
                        check_output("read_addr", 32'(src_addr), 32'(a));
                    end
                    if (buf_full) stall_reads++;
                end
                if (done) done_total++;
            end
        end
    end

    task automatic apply_stimulus(input int base, input int stride, input int len,
                                  input int rows, input int stall, input bit dup_start);
        int w0;
        int d0;
        int start_cyc;
        int done_cyc;
        int total;
        w0 = writes_total;
        d0 = done_total;
        total = len * rows;
        done_cyc = -1;
        first_write_cyc = -1;
        stall_reads = 0;
        stall_writes = 0;
        @(posedge clk);
        #1;
        base_addr = AW'(base);
        row_stride = AW'(stride);
        row_len = LW'(len);
        num_rows = LW'(rows);
        start = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = 8'hA5;
        row_len = 5'd7;
        check_output("busy_after_start", 32'(busy), (total > 0) ? 32'd1 : 32'd0);
        if (dup_start) begin
            @(posedge clk);
            #1;
            base_addr = 8'd99;
            row_len = 5'd2;
            num_rows = 5'd1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (stall > 0) begin
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (writes_total - w0 >= 2) break;
            end
            @(posedge clk);
            #1;
            buf_full = 1'b1;
            repeat (stall) @(posedge clk);
            #1;
            buf_full = 1'b0;
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check_output("done_seen", 32'(done_cyc >= 0), 32'd1);
        check_output("busy_at_done", 32'(busy), 32'd0);
        check_output("write_count", 32'(writes_total - w0), 32'(total));
        if (total > 0) begin
            check_output("first_write_latency", 32'(first_write_cyc - start_cyc), 32'd2);
            check_output("done_after_last_write", 32'(done_cyc - last_write_cyc), 32'd1);
        end else begin
            check_output("done_zero_frame", 32'(done_cyc - start_cyc), 32'd1);
        end
        if (stall > 0) begin
            check_output("stall_writes", 32'(stall_writes), 32'd0);
            check_output("stall_reads", 32'(stall_reads), 32'd1);
        end
        @(negedge clk);
        check_output("done_one_cycle", 32'(done), 32'd0);
        check_output("done_pulses", 32'(done_total - d0), 32'd1);
        check_output("words_left", 32'(exp_words.size()), 32'd0);
        check_output("reads_left", 32'(exp_addrs.size()), 32'd0);
        exp_words.delete();
        exp_addrs.delete();
    endtask

    task automatic push_test1();
        logic [FRAME_W-1:0] words [5];
        words = '{18'h200A1, 18'h000BE, 18'h0FF5F, 18'h0FFAF, 18'h10032};
        for (int i = 0; i < 5; i++) begin
            exp_addrs.push_back(AW'(i));
            exp_words.push_back(words[i]);
        end
    endtask

    task automatic push_listed(input logic [AW-1:0] addrs [], input logic [1:0] tags []);
        for (int i = 0; i < addrs.size(); i++) begin
            exp_addrs.push_back(addrs[i]);
            exp_words.push_back({tags[i], sram[addrs[i]]});
        end
    endtask

    initial begin
        logic [AW-1:0] addrs [];
        logic [1:0]    tags [];
        int            d0;
        for (int i = 0; i < 256; i++) sram[i] = DW'(i * 97 + 13);
        sram[0] = 16'd161;
        sram[1] = 16'd190;
        sram[2] = 16'hFF5F;
        sram[3] = 16'hFFAF;
        sram[4] = 16'd50;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_outputs",
                     32'({src_rd_en, src_addr, buf_write_en, buf_data, busy, done}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        $display("[TB] basic row");
        push_test1();
        apply_stimulus(0, 5, 5, 1, 0, 1'b0);

        $display("[TB] multi-row with stride");
        addrs = '{8'd10, 8'd11, 8'd12, 8'd18, 8'd19, 8'd20};
        tags  = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        push_listed(addrs, tags);
        apply_stimulus(10, 8, 3, 2, 0, 1'b0);

        $display("[TB] backpressure");
        push_test1();
        apply_stimulus(0, 5, 5, 1, 4, 1'b0);

        $display("[TB] degenerate sizes");
        expect_frame(40, 1, 1, 3);
        apply_stimulus(40, 1, 1, 3, 0, 1'b0);
        apply_stimulus(0, 1, 0, 3, 0, 1'b0);
        apply_stimulus(0, 1, 4, 0, 0, 1'b0);

        $display("[TB] second start while busy");
        expect_frame(30, 4, 4, 2);
        apply_stimulus(30, 4, 4, 2, 0, 1'b1);

        $display("[TB] reset mid-frame");
        d0 = done_total;
        expect_frame(0, 5, 5, 1);
        @(posedge clk);
        #1;
        base_addr = 8'd0;
        row_stride = 8'd5;
        row_len = 5'd5;
        num_rows = 5'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("reset_mid_frame_outputs",
                     32'({src_rd_en, src_addr, buf_write_en, buf_data, busy, done}), 32'd0);
        exp_words.delete();
        exp_addrs.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_output("no_done_after_reset", 32'(done_total - d0), 32'd0);
        push_test1();
        apply_stimulus(0, 5, 5, 1, 0, 1'b0);

        $display("[TB] address wrap");
        addrs = '{8'd254, 8'd255, 8'd0, 8'd1};
        tags  = '{2'b10, 2'b00, 2'b00, 2'b01};
        push_listed(addrs, tags);
        apply_stimulus(254, 4, 4, 1, 0, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
